// File: rtl/lru_wb_cache_if.sv
// -----------------------------------------------------------------------------
// lru_wb_cache_if
// Bus bundle for lru_wb_cache: requester side (req_*/resp_*) and backing
// memory side (mem_*).
//   slave  : cache view. Requests and memory responses in; responses and
//            memory requests out.
//   master : environment view (requester plus memory), mirror of slave.
// Parameters: ADDR_WIDTH (word address width), DATA_WIDTH (word width).
// -----------------------------------------------------------------------------
interface lru_wb_cache_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_hit;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_hit,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_hit,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lru_wb_cache.sv
// -----------------------------------------------------------------------------
// lru_wb_cache
// Fully associative true-LRU word cache with miss handling. On a miss the LRU
// entry is evicted (written back first if dirty) and the word is filled from
// backing memory over a mem_req/mem_ack handshake, then the request completes
// with a one-cycle resp_valid pulse.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - lru_wb_cache_if.slave: req_valid/req_ready/req_we/req_addr/req_wdata,
//          resp_valid/resp_rdata/resp_hit, mem_req/mem_we/mem_addr/mem_wdata,
//          mem_ack/mem_rdata
//
// Build option CACHE_WRITE_BACK_EN: write-back with write-allocate. When not
// defined the cache is write-through, no-write-allocate.
//
// Entries are stored in recency order: position 0 = MRU, CELL_CNT-1 = LRU.
// -----------------------------------------------------------------------------
module lru_wb_cache #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CELL_CNT   = 4
) (
   input  logic          clk,
   input  logic          rst,
   lru_wb_cache_if.slave bus
);
   localparam int unsigned      IDX_W = $clog2(CELL_CNT);
   localparam logic [IDX_W-1:0] LRU   = IDX_W'(CELL_CNT - 1);
`ifdef CACHE_WRITE_BACK_EN
   localparam bit WRITE_BACK = 1'b1;
`else
   localparam bit WRITE_BACK = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, MEMWR, RESP} state_t;
   state_t state, next_state;

   logic [CELL_CNT-1:0]                 c_valid;
   logic [CELL_CNT-1:0]                 c_dirty;
   logic [CELL_CNT-1:0][ADDR_WIDTH-1:0] c_addr;
   logic [CELL_CNT-1:0][DATA_WIDTH-1:0] c_data;

   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  ready_q;
   logic                  hit_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  xfer;
   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic                  lru_dirty;
   logic                  upd_en;
   logic [IDX_W-1:0]      upd_idx;
   logic                  upd_dirty;
   logic [DATA_WIDTH-1:0] upd_data;
   logic                  clr_lru_dirty;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   // ready_q is high exactly while the FSM sits in IDLE (after reset release)
   assign xfer      = bus.req_valid && ready_q;
   assign lru_dirty = c_valid[LRU] && c_dirty[LRU];

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < CELL_CNT; i++) begin
         if (c_valid[IDX_W'(i)] && (c_addr[IDX_W'(i)] == lat_addr)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Every order update is "move entry at upd_idx to position 0 with new
   // contents"; an install is the same move applied to the LRU slot.
   always_comb begin
      next_state    = state;
      upd_en        = 1'b0;
      upd_idx       = hit_idx;
      upd_dirty     = 1'b0;
      upd_data      = lat_wdata;
      clr_lru_dirty = 1'b0;
      case (state)
         IDLE: if (xfer) next_state = LOOKUP;
         LOOKUP: begin
            if (hit) begin
               upd_en = 1'b1;
               if (!lat_we) begin
                  upd_data   = c_data[hit_idx];
                  upd_dirty  = c_dirty[hit_idx];
                  next_state = RESP;
               end else begin
                  upd_dirty  = WRITE_BACK;
                  next_state = WRITE_BACK ? RESP : MEMWR;
               end
            end else if (lru_dirty) begin
               next_state = EVICT;
            end else if (!lat_we) begin
               next_state = FILL;
            end else if (WRITE_BACK) begin
               upd_en     = 1'b1;
               upd_idx    = LRU;
               upd_dirty  = 1'b1;
               next_state = RESP;
            end else begin
               next_state = MEMWR;
            end
         end
         EVICT: begin
            if (bus.mem_ack) begin
               if (lat_we) begin
                  upd_en     = 1'b1;
                  upd_idx    = LRU;
                  upd_dirty  = WRITE_BACK;
                  next_state = RESP;
               end else begin
                  // Read miss: mark the victim clean and revisit LOOKUP, which
                  // then picks FILL. The LOOKUP cycle is the mem_req gap
                  // between write-back and fill.
                  clr_lru_dirty = 1'b1;
                  next_state    = LOOKUP;
               end
            end
         end
         FILL: begin
            if (bus.mem_ack) begin
               upd_en     = 1'b1;
               upd_idx    = LRU;
               upd_data   = bus.mem_rdata;
               next_state = RESP;
            end
         end
         MEMWR: if (bus.mem_ack) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_valid   <= '0;
         c_dirty   <= '0;
         c_addr    <= '0;
         c_data    <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ready_q   <= 1'b0;
         hit_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ready_q <= (next_state == IDLE);
         if (xfer) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            hit_q     <= 1'b0;
            rdata_q   <= '0;
         end
         if (state == LOOKUP) begin
            hit_q <= hit;
            if (hit && !lat_we) rdata_q <= c_data[hit_idx];
         end
         if ((state == FILL) && bus.mem_ack) rdata_q <= bus.mem_rdata;
         if (upd_en) begin
            for (int unsigned i = 1; i < CELL_CNT; i++) begin
               if (i <= 32'(upd_idx)) begin
                  c_valid[IDX_W'(i)] <= c_valid[IDX_W'(i - 1)];
                  c_dirty[IDX_W'(i)] <= c_dirty[IDX_W'(i - 1)];
                  c_addr[IDX_W'(i)]  <= c_addr[IDX_W'(i - 1)];
                  c_data[IDX_W'(i)]  <= c_data[IDX_W'(i - 1)];
               end
            end
            c_valid[0] <= 1'b1;
            c_dirty[0] <= upd_dirty;
            c_addr[0]  <= lat_addr;
            c_data[0]  <= upd_data;
         end
         if (clr_lru_dirty) c_dirty[LRU] <= 1'b0;
      end
   end

   always_comb begin
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      case (state)
         EVICT: begin
            mem_addr_c  = c_addr[LRU];
            mem_wdata_c = c_data[LRU];
         end
         FILL:  mem_addr_c = lat_addr;
         MEMWR: begin
            mem_addr_c  = lat_addr;
            mem_wdata_c = lat_wdata;
         end
         default: ;
      endcase
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_hit   = hit_q;
   assign bus.mem_req    = (state == EVICT) || (state == FILL) || (state == MEMWR);
   assign bus.mem_we     = (state == EVICT) || (state == MEMWR);
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_c;
endmodule

// File: tb/tb_lru_wb_cache.sv
// -----------------------------------------------------------------------------
// tb_lru_wb_cache
// Drives lru_wb_cache through directed and random request sequences against a
// queue-based LRU reference model and a behavioural backing memory with
// configurable ack latency. Honours CACHE_WRITE_BACK_EN like the design.
// -----------------------------------------------------------------------------
module tb_lru_wb_cache;
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 8;
   localparam int unsigned CELLS = 4;
`ifdef CACHE_WRITE_BACK_EN
   localparam bit WB_MODE = 1'b1;
`else
   localparam bit WB_MODE = 1'b0;
`endif

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } op_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          dirty;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lru_wb_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   lru_wb_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CELL_CNT(CELLS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   bit abort = 1'b0;

   logic [DW-1:0] mem     [2**AW];
   logic [DW-1:0] ref_mem [2**AW];
   ent_t lru_q   [$];
   op_t  exp_ops [$];
   op_t  mem_log [$];
   int   lat_mode = -1;
   int   wait_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Backing memory: ack after wait_cnt idle mem_req cycles
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = 1'b0;
         if (bus.mem_req) begin
            if (wait_cnt <= 0) begin
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               else            bus.mem_rdata = mem[bus.mem_addr];
               mem_log.push_back(op_t'{bus.mem_we, bus.mem_addr,
                                       bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr]});
               bus.mem_ack = 1'b1;
               wait_cnt = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   // Reference: list ordered MRU first; absent entries = invalid tail
   function automatic void model_req(input logic we, input logic [AW-1:0] a,
                                     input logic [DW-1:0] wd,
                                     output logic hit, output logic [DW-1:0] rd);
      int   pos = -1;
      ent_t e;
      exp_ops.delete();
      foreach (lru_q[i]) if (lru_q[i].addr == a) pos = i;
      hit = (pos >= 0);
      rd  = '0;
      if (hit) begin
         e = lru_q[pos];
         lru_q.delete(pos);
         if (!we) begin
            rd = e.data;
         end else begin
            e.data = wd;
            if (WB_MODE) e.dirty = 1'b1;
            else begin
               ref_mem[a] = wd;
               exp_ops.push_back(op_t'{1'b1, a, wd});
            end
         end
         lru_q.push_front(e);
      end else if (!we || WB_MODE) begin
         if (lru_q.size() == CELLS) begin
            e = lru_q.pop_back();
            if (e.dirty) begin
               exp_ops.push_back(op_t'{1'b1, e.addr, e.data});
               ref_mem[e.addr] = e.data;
            end
         end
         if (we) begin
            lru_q.push_front(ent_t'{a, wd, 1'b1});
         end else begin
            rd = ref_mem[a];
            exp_ops.push_back(op_t'{1'b0, a, rd});
            lru_q.push_front(ent_t'{a, rd, 1'b0});
         end
      end else begin
         ref_mem[a] = wd;
         exp_ops.push_back(op_t'{1'b1, a, wd});
      end
   endfunction

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bit rdy = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            rdy = 1'b1;
            break;
         end
      end
      if (!rdy) begin
         check_val("ready_timeout", 32'(rdy), 32'd1);
         abort = 1'b1;
      end
      mem_log.delete();
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input string tag);
      logic          exp_hit;
      logic [DW-1:0] exp_rd;
      int            n   = 0;
      bit            got = 1'b0;
      if (abort) return;
      model_req(we, a, wd, exp_hit, exp_rd);
      issue(we, a, wd);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         n++;
         if (bus.resp_valid) begin
            got = 1'b1;
            break;
         end
      end
      check_val({tag, "_resp"}, 32'(got), 32'd1);
      if (!got) begin
         abort = 1'b1;
         return;
      end
      check_val({tag, "_rdata"}, 32'(bus.resp_rdata), 32'(exp_rd));
      check_val({tag, "_hit"}, 32'(bus.resp_hit), 32'(exp_hit));
      check_val({tag, "_nops"}, 32'(mem_log.size()), 32'(exp_ops.size()));
      for (int i = 0; i < mem_log.size() && i < exp_ops.size(); i++)
         check_val({tag, "_op"}, 32'(mem_log[i]), 32'(exp_ops[i]));
      if (exp_hit && exp_ops.size() == 0) check_val({tag, "_lat"}, 32'(n), 32'd2);
      @(negedge clk);
      check_val({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      logic [AW-1:0] seq [8];
      logic [AW-1:0] prev;
      bit            seen;
      bit            rv;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 2**AW; i++) begin
         mem[i]     = DW'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8'h10]     = 8'hAB;
      ref_mem[8'h10] = 8'hAB;

      // reset values
      repeat (2) @(negedge clk);
      check_val("rst_ready", 32'(bus.req_ready), 32'd0);
      check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_val("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
      check_val("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
      check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check_val("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      rst = 1'b1;
      #1;
      check_val("rel_ready_before_edge", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      check_val("rel_ready_after_edge", 32'(bus.req_ready), 32'd1);

      // fill then hit at 0x10, memory ack after 3 cycles
      lat_mode = 3;
      wait_cnt = 3;
      do_req(1'b0, 8'h10, '0, "t1_miss");
      do_req(1'b0, 8'h10, '0, "t1_hit");
      lat_mode = -1;

      // LRU order: 1,2,3,4,1,5 evicts 2
      seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd5, 8'd2, 8'd1};
      foreach (seq[i]) do_req(1'b0, seq[i], '0, $sformatf("lru%0d", i));

      // dirty write then four fills
      do_req(1'b1, 8'h20, 8'h55, "wb_wr");
      for (int i = 1; i <= 4; i++) do_req(1'b0, AW'(8'h20 + i), '0, $sformatf("wb_rd%0d", i));

      // write miss then read
      do_req(1'b1, 8'h30, 8'h66, "wt_wr");
      do_req(1'b0, 8'h30, '0, "wt_rd");

      // zero-wait memory, repeated hits at MRU
      lat_mode = 0;
      wait_cnt = 0;
      do_req(1'b0, 8'h50, '0, "zw_miss");
      do_req(1'b0, 8'h50, '0, "zw_hit0");
      do_req(1'b1, 8'h50, 8'h11, "zw_wr");
      do_req(1'b0, 8'h50, '0, "zw_hit1");
      do_req(1'b0, 8'h51, '0, "zw_miss2");

      // reset while a fill is outstanding
      lat_mode = 3;
      wait_cnt = 3;
      prev = lru_q[0].addr;
      if (!abort) begin
         issue(1'b0, 8'h80, '0);
         seen = 1'b0;
         for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #2;
            if (bus.mem_req) begin
               seen = 1'b1;
               break;
            end
         end
         check_val("mid_rst_memreq_seen", 32'(seen), 32'd1);
         rst = 1'b0;
         #1;
         check_val("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
         check_val("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
         check_val("mid_rst_ready", 32'(bus.req_ready), 32'd0);
         lru_q.delete();
         repeat (2) @(negedge clk);
         rst = 1'b1;
         rv = 1'b0;
         repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid) rv = 1'b1;
         end
         check_val("mid_rst_no_resp", 32'(rv), 32'd0);
         do_req(1'b0, prev, '0, "post_rst");
      end

      // random traffic over a small address pool
      lat_mode = -1;
      for (int i = 0; i < 150; i++) begin
         do_req(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom),
                $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
